axi_txn_scheduler: RTL and testbench
====================================

// Module: axi_txn_scheduler
// PURPOSE
// - Round-robin command scheduler in front of the AXI4 master. Shares one master between NREQ requesters.
// - Grants one command at a time and drives the master's start_read/start_write plus burst configuration.
// - Watches the AXI handshakes for completion, then returns one completion record per command.
// - Sits between the test sequencer or CPU-side requesters and the master_gld port of AXI_if.
// PARAMETERS
// - NREQ      default 2     number of requesters (2..8)
// - TIMEOUT   default 1024  cycles allowed in WAIT before a forced error completion
// - ID_W      default $clog2(NREQ)  width of the grant/done id
// PORTS
// - aclk         in   1            clock, rising edge
// - areset_n     in   1            synchronous active-low reset
// - req_valid    in   NREQ         per-requester command valid
// - req_ready    out  NREQ         one-hot accept strobe; at most one bit high
// - req_write    in   NREQ         1 = write command, 0 = read command
// - req_addr     in   NREQ x addr_t   start address per requester
// - req_len      in   NREQ x len_t    burst length minus 1
// - req_size     in   NREQ x size_t   beat size
// - req_burst    in   NREQ x burst_t  burst type
// - start_read   out  1            1-cycle pulse to the AXI master
// - start_write  out  1            1-cycle pulse to the AXI master
// - cmd_addr/cmd_len/cmd_size/cmd_burst  out  typed  latched config, stable from ISSUE until DONE
// - busy         out  1            high in every state except IDLE
// - rvalid,rready,rlast,rresp  in  1,1,1,resp_t    read data channel monitor
// - bvalid,bready,bresp        in  1,1,resp_t      write response monitor
// - done_valid   out  1            1-cycle completion pulse
// - done_id      out  ID_W         requester that owns the completion
// - done_resp    out  resp_t       final response
// - done_timeout out  1            1 = completion was forced by the watchdog
// BEHAVIOUR
// - Reset: all outputs go to 0 and cmd_* to 0. FSM=IDLE, rr_ptr=0, watchdog=0, worst_resp=OKAY.
// - States:
//   - IDLE: if any req_valid, the winner is the first valid index at or above rr_ptr (wrapping).
//     Assert req_ready[winner] combinationally this cycle. Latch the command and id. Go to ISSUE.
//   - ISSUE: pulse start_write or start_read for exactly one cycle. Go to WAIT.
//   - WAIT, write command: complete on the first cycle with bvalid & bready. Result = bresp.
//   - WAIT, read command: on every rvalid & rready beat, worst_resp = max(worst_resp, rresp).
//     Complete on the beat with rlast. Result = max(worst_resp, rresp).
//   - DONE: done_valid=1 for one cycle. rr_ptr = (id+1) mod NREQ. Clear worst_resp and watchdog. Go to IDLE.
// - Latency: accept in cycle N -> start pulse in N+1 -> earliest done_valid is 1 cycle after the completing handshake.
// - Throughput: at most one outstanding command. A new grant is possible in the cycle after DONE.
// - Watchdog: counts cycles in WAIT.
//   - When it reaches TIMEOUT-1 without a completion: go to DONE with done_resp=SLVERR and done_timeout=1.
//   - Late responses that arrive after the timeout are ignored in IDLE.
// - Simultaneous events:
//   - The completing handshake has priority over the timeout when both occur in the same cycle.
//   - Requests that arrive during a non-IDLE state stay pending. req_valid must hold until req_ready.
// - A requester that drops req_valid before it is granted is simply skipped. No state is kept for it.
// - Reset mid-operation: return to IDLE immediately. No done_valid is generated for the aborted command.
// - rr_ptr wraps from NREQ-1 to 0. Width rules: the watchdog counter is $clog2(TIMEOUT)+1 bits.
// STRUCTURE
// - shared_pkg: addr_t, len_t, size_t, burst_t, resp_t (already present).
// - shared_pkg additions: sched_state_e {IDLE, ISSUE, WAIT, DONE} and the RESP_OKAY/RESP_SLVERR constants.
// - Sub-module rr_arbiter #(NREQ): inputs req and ptr, outputs a one-hot grant. Purely combinational.
// - The FSM, latches and watchdog stay in the top level.
// TESTING
// - Single write, req_valid=01, len=3: req_ready=01 same cycle; start_write 1 cycle later; bvalid&bready with bresp=OKAY -> done_valid, done_id=0, done_resp=OKAY.
// - Read, len=3, rresp sequence OKAY, SLVERR, OKAY, OKAY (rlast on beat 4) -> done_resp=SLVERR, done_timeout=0.
// - Both requesters valid continuously for 4 commands -> grant order 0,1,0,1; one start pulse per command.
// - TIMEOUT=16, write, bvalid never asserted -> done_valid 16 cycles after entering WAIT, done_resp=SLVERR, done_timeout=1.
// - bvalid&bready on the final watchdog cycle -> normal completion with bresp, done_timeout=0.
// - areset_n low for 1 cycle during WAIT -> busy=0 next cycle, no done_valid, next grant goes to index 0.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared AXI field types plus the scheduler state encoding and response helpers.
package shared_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [7:0]  len_t;
    typedef logic [2:0]  size_t;
    typedef logic [1:0]  burst_t;
    typedef logic [1:0]  resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // AXI response codes are ordered by severity, so the worst is the numeric max.
    function automatic resp_t resp_max(input resp_t a, input resp_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Round-robin command scheduler sharing one AXI master among NREQ requesters,
// one outstanding command at a time, with a completion watchdog.
module axi_txn_scheduler
    import shared_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_write,
    input  addr_t             req_addr  [NREQ],
    input  len_t              req_len   [NREQ],
    input  size_t             req_size  [NREQ],
    input  burst_t            req_burst [NREQ],
    output logic              start_read,
    output logic              start_write,
    output addr_t             cmd_addr,
    output len_t              cmd_len,
    output size_t             cmd_size,
    output burst_t            cmd_burst,
    output logic              busy,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    input  resp_t             rresp,
    input  logic              bvalid,
    input  logic              bready,
    input  resp_t             bresp,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id,
    output resp_t             done_resp,
    output logic              done_timeout,
    output sched_state_e      dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    // Handshake rule: a command transfers in the cycle where req_valid[i] and
    // req_ready[i] are both high; the requester holds valid and payload until then.

    sched_state_e    state_q, state_d;
    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [ID_W-1:0] win_id, id_q, rr_ptr_q;
    logic            write_q;
    logic [WD_W-1:0] wd_q;
    resp_t           worst_q, res_q, res_d;
    logic            to_q, to_d;
    logic            rd_beat, wr_hs, wd_expired;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_id = ID_W'(i);
        end
    end

    assign any_grant  = |grant;
    assign rd_beat    = rvalid & rready;
    assign wr_hs      = bvalid & bready;
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    // A completing handshake wins over the watchdog in the same cycle.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        to_d    = to_q;
        case (state_q)
            IDLE:  if (any_grant) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (write_q && wr_hs) begin
                    state_d = DONE;
                    res_d   = bresp;
                    to_d    = 1'b0;
                end else if (!write_q && rd_beat && rlast) begin
                    state_d = DONE;
                    res_d   = resp_max(worst_q, rresp);
                    to_d    = 1'b0;
                end else if (wd_expired) begin
                    state_d = DONE;
                    res_d   = RESP_SLVERR;
                    to_d    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            res_q     <= RESP_OKAY;
            to_q      <= 1'b0;
            id_q      <= '0;
            rr_ptr_q  <= '0;
            write_q   <= 1'b0;
            wd_q      <= '0;
            worst_q   <= RESP_OKAY;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_size  <= '0;
            cmd_burst <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            to_q    <= to_d;
            case (state_q)
                IDLE: begin
                    if (any_grant) begin
                        id_q      <= win_id;
                        write_q   <= req_write[win_id];
                        cmd_addr  <= req_addr[win_id];
                        cmd_len   <= req_len[win_id];
                        cmd_size  <= req_size[win_id];
                        cmd_burst <= req_burst[win_id];
                        worst_q   <= RESP_OKAY;
                        wd_q      <= '0;
                    end
                end
                WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    if (!write_q && rd_beat) worst_q <= resp_max(worst_q, rresp);
                end
                DONE: begin
                    rr_ptr_q <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                    worst_q  <= RESP_OKAY;
                    wd_q     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE && areset_n) ? grant : '0;
    assign start_read   = (state_q == ISSUE) && !write_q;
    assign start_write  = (state_q == ISSUE) && write_q;
    assign busy         = (state_q != IDLE);
    assign done_valid   = (state_q == DONE);
    assign done_id      = done_valid ? id_q : '0;
    assign done_resp    = done_valid ? res_q : RESP_OKAY;
    assign done_timeout = done_valid & to_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed bench for axi_txn_scheduler with NREQ=2 and a short watchdog (TIMEOUT=16).
module tb_axi_txn_scheduler;
    import shared_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = 1;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_write;
    addr_t             req_addr  [NREQ];
    len_t              req_len   [NREQ];
    size_t             req_size  [NREQ];
    burst_t            req_burst [NREQ];
    logic              start_read, start_write, busy;
    addr_t             cmd_addr;
    len_t              cmd_len;
    size_t             cmd_size;
    burst_t            cmd_burst;
    logic              rvalid, rready, rlast, bvalid, bready;
    resp_t             rresp, bresp;
    logic              done_valid, done_timeout;
    logic [ID_W-1:0]   done_id;
    resp_t             done_resp;
    sched_state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi_txn_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
        .start_read(start_read), .start_write(start_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .busy(busy),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
        .done_timeout(done_timeout), .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input addr_t a, input len_t l);
        req_write[i] = wr;
        req_addr[i]  = a;
        req_len[i]   = l;
        req_size[i]  = 3'd2;
        req_burst[i] = 2'd1;
    endtask

    initial begin
        areset_n  = 1'b0;
        req_valid = '0;
        req_write = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
        {rvalid, rready, rlast, bvalid, bready} = '0;
        rresp = RESP_OKAY;
        bresp = RESP_OKAY;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_start", {start_read, start_write}, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        areset_n = 1'b1;
        tick();

        // Single write on requester 0, len=3
        set_req(0, 1'b1, 32'h1000, 8'd3);
        req_valid = 2'b01;
        #1;
        chk("w_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("w_start_write", start_write, 1);
        chk("w_start_read", start_read, 0);
        chk("w_busy", busy, 1);
        chk("w_cmd_addr", cmd_addr, 32'h1000);
        chk("w_cmd_len", cmd_len, 3);
        chk("w_cmd_size", cmd_size, 2);
        tick();
        chk("w_start_once", start_write, 0);
        chk("w_no_early_done", done_valid, 0);
        bvalid = 1'b1; bready = 1'b1; bresp = RESP_OKAY;
        tick();
        bvalid = 1'b0; bready = 1'b0;
        chk("w_done", done_valid, 1);
        chk("w_done_id", done_id, 0);
        chk("w_done_resp", done_resp, RESP_OKAY);
        chk("w_done_to", done_timeout, 0);
        tick();
        chk("w_idle_done", done_valid, 0);
        chk("w_idle_busy", busy, 0);

        // Read on requester 1 (pointer now 1), worst response SLVERR
        set_req(1, 1'b0, 32'h2000, 8'd3);
        req_valid = 2'b10;
        #1;
        chk("r_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("r_start_read", start_read, 1);
        chk("r_start_write", start_write, 0);
        chk("r_cmd_addr", cmd_addr, 32'h2000);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("r_no_done_mid", done_valid, 0);
            rvalid = 1'b1; rready = 1'b1;
            rresp  = (b == 1) ? RESP_SLVERR : RESP_OKAY;
            rlast  = (b == 3);
            tick();
        end
        {rvalid, rready, rlast} = '0;
        rresp = RESP_OKAY;
        chk("r_done", done_valid, 1);
        chk("r_done_id", done_id, 1);
        chk("r_done_resp", done_resp, RESP_SLVERR);
        chk("r_done_to", done_timeout, 0);
        tick();

        // Both requesters valid for four commands: 0,1,0,1
        set_req(0, 1'b1, 32'h3000, 8'd0);
        set_req(1, 1'b1, 32'h4000, 8'd0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("rr_start", start_write, 1);
            chk("rr_ready_busy", req_ready, 0);
            chk("rr_cmd_addr", cmd_addr, (k % 2 == 0) ? 32'h3000 : 32'h4000);
            tick();
            chk("rr_start_once", start_write, 0);
            bvalid = 1'b1; bready = 1'b1; bresp = RESP_OKAY;
            tick();
            bvalid = 1'b0; bready = 1'b0;
            chk("rr_done", done_valid, 1);
            chk("rr_done_id", done_id, k % 2);
            tick();
        end
        req_valid = 2'b00;

        // Watchdog: requester 0 write, bvalid never arrives
        set_req(0, 1'b1, 32'h5000, 8'd1);
        req_valid = 2'b01;
        #1;
        chk("to_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            chk("to_wait_no_done", done_valid, 0);
            tick();
        end
        chk("to_last_no_done", done_valid, 0);
        chk("to_last_busy", busy, 1);
        tick();
        chk("to_done", done_valid, 1);
        chk("to_done_id", done_id, 0);
        chk("to_done_resp", done_resp, RESP_SLVERR);
        chk("to_done_flag", done_timeout, 1);
        tick();
        bvalid = 1'b1; bready = 1'b1; bresp = RESP_OKAY;
        tick();
        bvalid = 1'b0; bready = 1'b0;
        chk("to_late_ignored", done_valid, 0);
        chk("to_late_busy", busy, 0);

        // Handshake on the final watchdog cycle completes normally
        set_req(1, 1'b1, 32'h6000, 8'd0);
        req_valid = 2'b10;
        #1;
        chk("edge_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("edge_no_done", done_valid, 0);
        bvalid = 1'b1; bready = 1'b1; bresp = 2'b01;
        tick();
        bvalid = 1'b0; bready = 1'b0; bresp = RESP_OKAY;
        chk("edge_done", done_valid, 1);
        chk("edge_done_id", done_id, 1);
        chk("edge_done_resp", done_resp, 2'b01);
        chk("edge_done_to", done_timeout, 0);
        tick();

        // Move pointer to 1 with a short write on requester 0
        set_req(0, 1'b1, 32'h7000, 8'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0; bready = 1'b0;
        chk("pre_rst_done_id", done_id, 0);
        tick();

        // Reset during WAIT of a requester 1 command
        set_req(1, 1'b1, 32'h8000, 8'd0);
        req_valid = 2'b10;
        #1;
        chk("mr_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        chk("mr_in_wait", busy, 1);
        areset_n = 1'b0;
        tick();
        chk("mr_busy_cleared", busy, 0);
        chk("mr_no_done", done_valid, 0);
        areset_n = 1'b1;
        tick();
        chk("mr_no_done_after", done_valid, 0);
        set_req(0, 1'b1, 32'h9000, 8'd0);
        req_valid = 2'b11;
        #1;
        chk("mr_grant_idx0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("mr_cmd_addr", cmd_addr, 32'h9000);
        tick();
        bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0; bready = 1'b0;
        chk("mr_done_id", done_id, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
